// File: rtl/cpu_pkg.sv
// Shared types and defaults for the register-file sequencer.
// Opcodes, sequencer states and datapath widths live here.
package cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_X = 3'd1,
    S_RD_Y = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer.
// Produces result, carry/borrow and zero flag.
module rf_alu
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // diff[DW] is set exactly when a < b unsigned
  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (1'b1)
      op == OP_MV:  result = a;
      op == OP_MVI: result = imm;
      op == OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      op == OP_SUB: begin
        result = diff[DW-1:0];
        carry  = diff[DW];
      end
      op == OP_AND: result = a & b;
      op == OP_OR:  result = a | b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Sequences read-execute-writeback over an external register file.
// All register-file and status outputs come straight from flops.
module rf_sequencer
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rx,
  input  logic [AW-1:0] instr_ry,
  input  logic [DW-1:0] instr_imm,
  output logic [AW-1:0] rf_reg_num,
  output logic          rf_rd_wr,
  output logic [DW-1:0] rf_d_in,
  input  logic [DW-1:0] rf_d_out,
  output logic          done,
  output logic          err,
  output logic          carry,
  output logic          zero
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] ry_q, ry_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          cy_q, cy_d;
  logic          zr_q, zr_d;

  logic [AW-1:0] num_q, num_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] din_q, din_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;

  logic [DW-1:0] alu_res;
  logic          alu_cy;
  logic          alu_zr;

  rf_alu #(
    .DW(DW)
  ) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .result(alu_res),
    .carry (alu_cy),
    .zero  (alu_zr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ry_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      zr_q    <= 1'b0;
      num_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ry_q    <= ry_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      zr_q    <= zr_d;
      num_q   <= num_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs for a state are registered on the edge that enters it
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ry_d    = ry_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    zr_d    = zr_q;
    num_d   = '0;
    wr_d    = 1'b0;
    din_d   = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d  = instr_op;
          rd_d  = instr_rd;
          ry_d  = instr_ry;
          imm_d = instr_imm;
          if (!op_legal(instr_op)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            carry_d = 1'b0;
            zero_d  = 1'b0;
          end else if (instr_op == OP_MVI) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_RD_X;
            num_d   = instr_rx;
          end
        end
      end
      S_RD_X: begin
        a_d = rf_d_out;
        if (op_q == OP_MV) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_RD_Y;
          num_d   = ry_q;
        end
      end
      S_RD_Y: begin
        b_d     = rf_d_out;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cy_d    = alu_cy;
        zr_d    = alu_zr;
        state_d = S_WB;
        num_d   = rd_q;
        wr_d    = 1'b1;
        din_d   = alu_res;
      end
      S_WB: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        err_d   = 1'b0;
        carry_d = cy_q;
        zero_d  = zr_q;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_ready = (state_q == S_IDLE);
  assign rf_reg_num  = num_q;
  assign rf_rd_wr    = wr_q;
  assign rf_d_in     = din_q;
  assign done        = done_q;
  assign err         = err_q;
  assign carry       = carry_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer with a behavioural register
// file and an arithmetic reference model.
module tb_rf_sequencer;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rx;
  logic [AW-1:0] instr_ry;
  logic [DW-1:0] instr_imm;
  logic [AW-1:0] rf_reg_num;
  logic          rf_rd_wr;
  logic [DW-1:0] rf_d_in;
  logic [DW-1:0] rf_d_out;
  logic          done;
  logic          err;
  logic          carry;
  logic          zero;

  logic [DW-1:0] mem  [8];
  logic [DW-1:0] gold [8];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_sequencer #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_rd   (instr_rd),
    .instr_rx   (instr_rx),
    .instr_ry   (instr_ry),
    .instr_imm  (instr_imm),
    .rf_reg_num (rf_reg_num),
    .rf_rd_wr   (rf_rd_wr),
    .rf_d_in    (rf_d_in),
    .rf_d_out   (rf_d_out),
    .done       (done),
    .err        (err),
    .carry      (carry),
    .zero       (zero)
  );

  assign rf_d_out = mem[rf_reg_num];

  always @(posedge clk) begin
    if (rf_rd_wr)
      mem[rf_reg_num] <= rf_d_in;
    else if (pre_we)
      mem[pre_addr] <= pre_data;
  end

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    gold[a]  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic junk_fields();
    instr_op  = 3'($urandom_range(0, 7));
    instr_rd  = 3'($urandom_range(0, 7));
    instr_rx  = 3'($urandom_range(0, 7));
    instr_ry  = 3'($urandom_range(0, 7));
    instr_imm = 16'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (instr_ready !== 1'b1 || rf_rd_wr !== 1'b0 || rf_reg_num !== 3'd0 ||
        rf_d_in !== 16'h0 || done !== 1'b0 || err !== 1'b0 ||
        carry !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b wr=%b num=%0d din=%h done=%b err=%b c=%b z=%b, want 1 0 0 0000 0 0 0 0",
               tag, instr_ready, rf_rd_wr, rf_reg_num, rf_d_in, done, err, carry, zero);
    end
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rx, input logic [2:0] ry,
                           input logic [15:0] imm, input string tag);
    int unsigned a, b, s;
    logic [15:0] exp_res;
    logic exp_c, exp_z, legal, seen;
    logic hold_e, hold_c, hold_z;
    int lat, writes, k;
    a = gold[rx];
    b = gold[ry];
    exp_c = 1'b0;
    legal = 1'b1;
    case (op)
      3'd0: begin exp_res = 16'(a); lat = 5; end
      3'd1: begin exp_res = imm; lat = 4; end
      3'd2: begin
        s = a + b;
        exp_res = 16'(s % 65536);
        exp_c = (s > 65535);
        lat = 6;
      end
      3'd3: begin
        exp_res = 16'((a + 65536 - b) % 65536);
        exp_c = (a < b);
        lat = 6;
      end
      3'd4: begin exp_res = 16'(a & b); lat = 6; end
      3'd5: begin exp_res = 16'(a | b); lat = 6; end
      default: begin exp_res = 16'h0; legal = 1'b0; lat = 2; end
    endcase
    exp_z = legal && (exp_res == 16'h0);

    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", tag, instr_ready);
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rx    = rx;
    instr_ry    = ry;
    instr_imm   = imm;
    @(posedge clk);
    #1 junk_fields();

    writes = 0;
    seen   = 1'b0;
    for (k = 2; k <= 20 && !seen; k++) begin
      @(negedge clk);
      n_checks++;
      if (instr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_ready cyc %0d: got %b want 0", tag, k, instr_ready);
      end
      n_checks++;
      if (rf_rd_wr === 1'b1) begin
        writes++;
        if (rf_reg_num !== rd || rf_d_in !== exp_res) begin
          n_fail++;
          $display("FAIL %s write: got R%0d=%h want R%0d=%h", tag, rf_reg_num, rf_d_in, rd, exp_res);
        end
      end else if (rf_d_in !== 16'h0) begin
        n_fail++;
        $display("FAIL %s din_idle cyc %0d: got %h want 0000", tag, k, rf_d_in);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        instr_valid = 1'b0;
        n_checks++;
        if (k != lat || err !== !legal || carry !== exp_c || zero !== exp_z) begin
          n_fail++;
          $display("FAIL %s done: cyc=%0d err=%b c=%b z=%b want cyc=%0d err=%b c=%b z=%b",
                   tag, k, err, carry, zero, lat, !legal, exp_c, exp_z);
        end
      end else begin
        junk_fields();
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      instr_valid = 1'b0;
      $display("FAIL %s timeout: got no done want done in cycle %0d", tag, lat);
    end
    n_checks++;
    if (writes != (legal ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d want %0d", tag, writes, legal ? 1 : 0);
    end
    hold_e = err;
    hold_c = carry;
    hold_z = zero;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1 || err !== hold_e ||
        carry !== hold_c || zero !== hold_z) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b rdy=%b e/c/z=%b%b%b want 0 1 %b%b%b",
               tag, done, instr_ready, err, carry, zero, hold_e, hold_c, hold_z);
    end
    if (legal) gold[rd] = exp_res;
    n_checks++;
    if (mem[rd] !== gold[rd]) begin
      n_fail++;
      $display("FAIL %s regfile: got R%0d=%h want %h", tag, rd, mem[rd], gold[rd]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) load(3'(i), 16'h0);
  endtask

  task automatic test_add();
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    run_instr(3'd2, 3'd3, 3'd1, 3'd2, 16'h0, "add_basic");
    n_checks++;
    if (mem[3] !== 16'h0008) begin
      n_fail++;
      $display("FAIL add_r3: got %h want 0008", mem[3]);
    end
  endtask

  task automatic test_add_carry();
    load(3'd1, 16'hFFFF);
    load(3'd2, 16'h0001);
    run_instr(3'd2, 3'd1, 3'd1, 3'd2, 16'h0, "add_carry");
    n_checks++;
    if (mem[1] !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_carry_flags: got R1=%h c=%b z=%b want 0000 1 1", mem[1], carry, zero);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    logic [15:0] r3;
    load(3'd1, 16'h1234);
    load(3'd2, 16'h1111);
    r3 = gold[3];
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'd2;
    instr_rd    = 3'd3;
    instr_rx    = 3'd1;
    instr_ry    = 3'd2;
    instr_imm   = 16'h0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rf_reg_num !== 3'd2 || rf_rd_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_phase: got num=%0d wr=%b want 2 0", rf_reg_num, rf_rd_wr);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_idle_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rf_rd_wr === 1'b1 || done === 1'b1) wr_seen++;
    end
    n_checks++;
    if (wr_seen != 0 || mem[3] !== r3) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d wr/done cycles R3=%h want 0 %h", wr_seen, mem[3], r3);
    end
  endtask

  task automatic test_sub();
    load(3'd4, 16'h0002);
    load(3'd5, 16'h0007);
    run_instr(3'd3, 3'd6, 3'd4, 3'd5, 16'h0, "sub_borrow");
    n_checks++;
    if (mem[6] !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL sub_r6: got %h want FFFB", mem[6]);
    end
  endtask

  task automatic test_mvi();
    run_instr(3'd1, 3'd7, 3'd0, 3'd0, 16'hA5A5, "mvi");
    n_checks++;
    if (mem[7] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL mvi_r7: got %h want A5A5", mem[7]);
    end
  endtask

  task automatic test_illegal();
    run_instr(3'd7, 3'd2, 3'd1, 3'd3, 16'hFFFF, "illegal_7");
    run_instr(3'd6, 3'd4, 3'd2, 3'd2, 16'h1234, "illegal_6");
  endtask

  task automatic test_random();
    logic [2:0] op, rd, rx, ry;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(6, 7));
      else op = 3'($urandom_range(0, 5));
      rd = 3'($urandom_range(0, 7));
      rx = 3'($urandom_range(0, 7));
      ry = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rd = rx;
      if ($urandom_range(0, 3) == 0) ry = rx;
      run_instr(op, rd, rx, ry, 16'($urandom), "random");
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rx    = '0;
    instr_ry    = '0;
    instr_imm   = '0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    test_reset();
    test_add();
    test_add_carry();
    test_reset_mid();
    test_sub();
    test_mvi();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning datapath and register width.
REQ-002 SHALL have parameter AW, default 3, meaning register-number width (8 registers).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port instr_valid  input  1  an instruction is presented.
REQ-006 SHALL have port instr_ready  output  1  the sequencer accepts an instruction this cycle.
REQ-007 SHALL have port instr_op  input  3  opcode: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND, 101 OR; others illegal.
REQ-008 SHALL have ports instr_rd, instr_rx, instr_ry  input  AW each  destination, first source and second source register numbers.
REQ-009 SHALL have port instr_imm  input  DW  immediate for MVI.
REQ-010 SHALL have port rf_reg_num  output  AW  register number driven to the register file.
REQ-011 SHALL have port rf_rd_wr  output  1  0 read, 1 write, driven to the register file.
REQ-012 SHALL have port rf_d_in  output  DW  write data to the register file.
REQ-013 SHALL have port rf_d_out  input  DW  read data from the register file, valid combinationally in the cycle rf_reg_num is driven.
REQ-014 SHALL have port done  output  1  one-cycle pulse on instruction completion.
REQ-015 SHALL have ports err  output  1, carry  output  1, zero  output  1  completion status, valid while done=1 and held until the next done.

Function
REQ-016 SHALL implement states IDLE, RD_X, RD_Y, EXEC, WB, DONE.
REQ-017 SHALL assert instr_ready only in IDLE; an instruction is accepted when instr_valid=1 and instr_ready=1; op, rd, rx, ry and imm SHALL be captured at that edge.
REQ-018 SHALL, on accept, go to RD_X for MV/ADD/SUB/AND/OR, to EXEC for MVI, and to DONE with err=1 for an illegal op.
REQ-019 SHALL in RD_X drive rf_reg_num=rx, rf_rd_wr=0, capture rf_d_out into operand A at the cycle end, then go to RD_Y (ALU ops) or EXEC (MV).
REQ-020 SHALL in RD_Y drive rf_reg_num=ry, rf_rd_wr=0, capture rf_d_out into operand B, then go to EXEC.
REQ-021 SHALL in EXEC register result: MV A; MVI imm; ADD A+B; SUB A-B; AND A&B; OR A|B; all modulo 2^DW.
REQ-022 SHALL set carry to the ADD carry-out, to the SUB borrow (1 when A<B unsigned), and to 0 for other ops.
REQ-023 SHALL set zero=1 when result equals 0, and err=0 for legal ops.
REQ-024 SHALL in WB drive rf_reg_num=rd, rf_rd_wr=1 and rf_d_in=result for exactly one cycle, then go to DONE.
REQ-025 SHALL in DONE pulse done=1 for one cycle, then return to IDLE; no back-to-back accept in DONE.
REQ-026 SHALL drive rf_rd_wr=1 in WB only and rf_d_in=0 outside WB.
REQ-027 SHALL drive rf_rd_wr, rf_reg_num and rf_d_in from flops, glitch-free.
REQ-028 SHALL complete in 6 cycles from accept for ALU ops, 5 for MV, 4 for MVI and 2 for illegal ops.
REQ-029 SHALL handle rd equal to rx or ry correctly, since all reads complete before WB.
REQ-030 SHALL ignore instr_* inputs outside the accept cycle.

Reset
REQ-031 SHALL, at any rising clk edge with rst_n=0, enter IDLE, including mid-instruction; any pending write SHALL be aborted.
REQ-032 SHALL reset outputs as follows: instr_ready=1 after reset, rf_rd_wr=0, rf_reg_num=0, rf_d_in=0, done=0, err=0, carry=0, zero=0; operand and result registers SHALL reset to 0.

Structure
REQ-033 SHALL take the opcode enum, state enum and DW/AW defaults from a shared package, cpu_pkg.
REQ-034 SHALL contain one sub-module, rf_alu, which is combinational and computes result, carry and zero from op, A, B and imm.

Verification
REQ-035 SHALL cover: R1=0x0005, R2=0x0003, ADD rd=3 rx=1 ry=2 -> WB writes R3=0x0008, carry=0, zero=0, done in cycle 6.
REQ-036 SHALL cover: R1=0xFFFF, R2=0x0001, ADD rd=1 rx=1 ry=2 -> R1=0x0000, carry=1, zero=1.
REQ-037 SHALL cover: R4=0x0002, R5=0x0007, SUB rd=6 rx=4 ry=5 -> R6=0xFFFB, carry=1 (borrow).
REQ-038 SHALL cover: MVI rd=7 imm=0xA5A5 -> R7=0xA5A5, done in cycle 4, and exactly one cycle with rf_rd_wr=1.
REQ-039 SHALL cover: op=111 -> no rf_rd_wr=1 cycle, done with err=1 in cycle 2.
REQ-040 SHALL cover: rst_n=0 asserted during RD_Y of an ADD -> no write occurs, IDLE next cycle, instr_ready=1, all outputs at reset values.
